// File: rtl/gray_counter.sv
// Up/down counter held in binary and presented as registered Gray code on g.
// Optional adjacency checker is built when GRAY_CNT_CHECK_EN is defined.
module gray_counter #(
    parameter int WIDTH   = 4,
    parameter int WRAP    = 1,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] bcnt,
    output logic             tc,
    output logic             wrap,
    output logic             chk_err
);

    localparam logic [WIDTH-1:0] MAX_B = '1;
    localparam logic [WIDTH-1:0] RST_B = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] RST_G = RST_B ^ (RST_B >> 1);

    logic [WIDTH-1:0] bcnt_q, bcnt_d;
    logic [WIDTH-1:0] g_q, g_d;
    logic             wrap_q, wrap_d;

    assign tc = up ? (bcnt_q == MAX_B) : (bcnt_q == '0);

    always_comb begin
        bcnt_d = bcnt_q;
        wrap_d = 1'b0;
        if (load) begin
            bcnt_d = load_bin;
        end else if (en) begin
            if (tc) begin
                // Terminal step either wraps to the opposite end or holds.
                if (WRAP != 0) begin
                    bcnt_d = up ? '0 : MAX_B;
                    wrap_d = 1'b1;
                end
            end else begin
                bcnt_d = up ? bcnt_q + WIDTH'(1) : bcnt_q - WIDTH'(1);
            end
        end
        g_d = bcnt_d ^ (bcnt_d >> 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt_q <= RST_B;
            g_q    <= RST_G;
            wrap_q <= 1'b0;
        end else begin
            bcnt_q <= bcnt_d;
            g_q    <= g_d;
            wrap_q <= wrap_d;
        end
    end

    assign g    = g_q;
    assign bcnt = bcnt_q;
    assign wrap = wrap_q;

`ifdef GRAY_CNT_CHECK_EN
    logic [WIDTH-1:0] gprev_q;
    logic [WIDTH-1:0] gdiff;
    logic             chk_vld_q;
    logic             chk_err_q;
    logic             jump_bad;

    // gprev_q/g_q bracket the previous edge; chk_vld_q says that edge was a plain step.
    assign gdiff    = g_q ^ gprev_q;
    assign jump_bad = chk_vld_q && (gdiff != '0) && ($countones(gdiff) != 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gprev_q   <= RST_G;
            chk_vld_q <= 1'b0;
            chk_err_q <= 1'b0;
        end else begin
            gprev_q   <= g_q;
            chk_vld_q <= !load;
            if (jump_bad) chk_err_q <= 1'b1;
        end
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule
